// File: rtl/systolic_sched.sv
// systolic_sched: buffers one A and one B matrix and streams them, diagonally skewed, into an N x N systolic array.
// Latency: start-to-done is 3N cycles, or 3N-1 with chain=1 under SCHED_CHAIN_EN. All outputs are registered.
// Backpressure: loads are accepted only in IDLE (ld_ready=1). The host holds ld_valid otherwise. start is ignored outside IDLE.
// Optional feature: SCHED_CHAIN_EN adds the 'chain' input. chain=1 skips CLEAR so the array accumulates onto its previous results.
// Ports: clk, reset_n (sync, active-low); start; ld_valid/ld_ready/ld_sel/ld_row/ld_col/ld_data (buffer write port);
//        busy, done (status); arr_clr (active-high PE reset); arr_a (row-edge feed), arr_b (column-edge feed).
module systolic_sched #(
    parameter int DATA_SIZE = 4,
    parameter int N         = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
`ifdef SCHED_CHAIN_EN
    input  logic                   chain,
`endif
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic                   ld_sel,
    input  logic [$clog2(N)-1:0]   ld_row,
    input  logic [$clog2(N)-1:0]   ld_col,
    input  logic [DATA_SIZE-1:0]   ld_data,
    output logic                   busy,
    output logic                   done,
    output logic                   arr_clr,
    output logic [N*DATA_SIZE-1:0] arr_a,
    output logic [N*DATA_SIZE-1:0] arr_b
);

    // The counter must reach 2N-2 (last FEED step).
    localparam int            CW         = $clog2(2 * N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          chain_go;
    logic          wr;

    logic [DATA_SIZE-1:0] a_buf  [N][N];
    logic [DATA_SIZE-1:0] b_buf  [N][N];
    logic [DATA_SIZE-1:0] a_view [N][N];
    logic [DATA_SIZE-1:0] b_view [N][N];

    logic                   ld_ready_nxt, busy_nxt, done_nxt, clr_nxt;
    logic [N*DATA_SIZE-1:0] a_nxt, b_nxt;

`ifdef SCHED_CHAIN_EN
    assign chain_go = chain;
`else
    assign chain_go = 1'b0;
`endif

    assign wr = ld_valid & ld_ready;

    // Buffer contents as they will be after this cycle's write.
    // Outputs are registered, so the next feed word is computed from this view.
    // A word loaded in the same cycle as a chained start is therefore already visible at t=0.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_view[i][j] = a_buf[i][j];
                b_view[i][j] = b_buf[i][j];
                if (wr && int'(ld_row) == i && int'(ld_col) == j) begin
                    if (ld_sel) b_view[i][j] = ld_data;
                    else        a_view[i][j] = ld_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!reset_n) begin
                    a_buf[i][j] <= '0;
                    b_buf[i][j] <= '0;
                end else begin
                    a_buf[i][j] <= a_view[i][j];
                    b_buf[i][j] <= b_view[i][j];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = chain_go ? S_FEED : S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                state_nxt = S_FEED;
                cnt_nxt   = '0;
            end
            S_FEED: begin
                if (cnt == FEED_LAST) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output values for the upcoming cycle, decoded from the next state.
    // Skew: at feed step t, row i carries A[i][k] and column j carries B[k][j], where k is the index with i+k==t (or j+k==t).
    always_comb begin
        ld_ready_nxt = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        clr_nxt      = 1'b0;
        a_nxt        = '0;
        b_nxt        = '0;
        case (state_nxt)
            S_IDLE:  ld_ready_nxt = 1'b1;
            S_CLEAR: begin
                clr_nxt  = 1'b1;
                busy_nxt = 1'b1;
            end
            S_FEED: begin
                busy_nxt = 1'b1;
                for (int i = 0; i < N; i++) begin
                    for (int k = 0; k < N; k++) begin
                        if (int'(cnt_nxt) == i + k) begin
                            a_nxt[i*DATA_SIZE +: DATA_SIZE] = a_view[i][k];
                            b_nxt[i*DATA_SIZE +: DATA_SIZE] = b_view[k][i];
                        end
                    end
                end
            end
            S_DRAIN: busy_nxt = 1'b1;
            S_DONE:  done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Output registers. In reset, arr_clr stays high so the array is held cleared.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ld_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            arr_clr  <= 1'b1;
            arr_a    <= '0;
            arr_b    <= '0;
        end else begin
            ld_ready <= ld_ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            arr_clr  <= clr_nxt;
            arr_a    <= a_nxt;
            arr_b    <= b_nxt;
        end
    end

endmodule

// File: tb/tb_systolic_sched.sv
// tb_systolic_sched: directed bench for systolic_sched (N=4, DATA_SIZE=4).
// Includes a behavioural 4x4 output-stationary array that consumes arr_a/arr_b/arr_clr, so the out_c results can be checked.
// Outputs are sampled on the falling edge. Inputs change on the falling edge, or #1 after the rising edge.
module tb_systolic_sched;

    logic        clk;
    logic        reset_n;
    logic        start;
`ifdef SCHED_CHAIN_EN
    logic        chain;
`endif
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_sel;
    logic [1:0]  ld_row;
    logic [1:0]  ld_col;
    logic [3:0]  ld_data;
    logic        busy;
    logic        done;
    logic        arr_clr;
    logic [15:0] arr_a;
    logic [15:0] arr_b;

    int errors = 0;
    int checks = 0;

    systolic_sched #(.DATA_SIZE(4), .N(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
`ifdef SCHED_CHAIN_EN
        .chain    (chain),
`endif
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_sel   (ld_sel),
        .ld_row   (ld_row),
        .ld_col   (ld_col),
        .ld_data  (ld_data),
        .busy     (busy),
        .done     (done),
        .arr_clr  (arr_clr),
        .arr_a    (arr_a),
        .arr_b    (arr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural array. Each PE accumulates a*b. Operands move one PE right (a) or down (b) per cycle.
    // Accumulators are 9 bits wide and wrap.
    logic [8:0] acc [4][4];
    logic [3:0] ar  [4][4];
    logic [3:0] br  [4][4];
    logic [3:0] ain [4][4];
    logic [3:0] bin [4][4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ain[i][0] = arr_a[i*4 +: 4];
            bin[0][i] = arr_b[i*4 +: 4];
            for (int j = 1; j < 4; j++) begin
                ain[i][j] = ar[i][j-1];
                bin[j][i] = br[j-1][i];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (arr_clr) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
                    ar[i][j]  <= ain[i][j];
                    br[i][j]  <= bin[i][j];
                end
            end
        end
    end

    typedef struct {
        logic        start;
        logic        busy;
        logic        done;
        logic        clr;
        logic        rdy;
        logic [15:0] a;
        logic [15:0] b;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic s, input logic bz, input logic dn, input logic cl,
                                input logic rd, input logic [15:0] a, input logic [15:0] b);
        vec_t v;
        v.start = s; v.busy = bz; v.done = dn; v.clr = cl; v.rdy = rd; v.a = a; v.b = b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic sel, input int r, input int c, input int d);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_row   = 2'(r);
        ld_col   = 2'(c);
        ld_data  = 4'(d);
        @(posedge clk);
        #1 ld_valid = 1'b0;
    endtask

    // Pulse start and count cycles until done (C0 = start cycle).
    // Also reports the OR of all feed words seen on the way.
    task automatic run_mult(input logic ch, output int lat, output logic [15:0] feed_or);
        @(negedge clk);
        start = 1'b1;
`ifdef SCHED_CHAIN_EN
        chain = ch;
`endif
        @(negedge clk);
        start = 1'b0;
`ifdef SCHED_CHAIN_EN
        chain = 1'b0;
`endif
        lat = 1;
        feed_or = arr_a | arr_b;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
            feed_or = feed_or | arr_a | arr_b;
        end
        if (ch) feed_or = feed_or; // chained runs have nonzero feeds; callers ignore it there
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int          lat;
    int          cyc;
    logic        early;
    logic [15:0] fo;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
`ifdef SCHED_CHAIN_EN
        chain    = 1'b0;
`endif
        ld_valid = 1'b0;
        ld_sel   = 1'b0;
        ld_row   = '0;
        ld_col   = '0;
        ld_data  = '0;

        // Expected cycle trace for A=I, B[r][c]=r*4+c. Row k is cycle Ck.
        // A second start is driven during C5 (FEED t=3) and must be ignored.
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0014);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0258);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h369C);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h7AD0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBE00);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'hF000);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);

        // Reset, then idle
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst ld_ready", ld_ready, 1);
        chk("rst arr_clr", arr_clr, 1);
        chk("rst arr_a", arr_a, 0);
        chk("rst arr_b", arr_b, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle arr_clr", arr_clr, 0);
        chk("idle ld_ready", ld_ready, 1);

        // Identity multiply, checked cycle by cycle against the table
        for (int i = 0; i < 4; i++) load(1'b0, i, i, 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) load(1'b1, r, c, r * 4 + c);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk($sformatf("c%0d busy", k), busy, tbl[k].busy);
            chk($sformatf("c%0d done", k), done, tbl[k].done);
            chk($sformatf("c%0d arr_clr", k), arr_clr, tbl[k].clr);
            chk($sformatf("c%0d ld_ready", k), ld_ready, tbl[k].rdy);
            chk($sformatf("c%0d arr_a", k), arr_a, tbl[k].a);
            chk($sformatf("c%0d arr_b", k), arr_b, tbl[k].b);
            if (k == 12) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        chk($sformatf("ident out_c[%0d][%0d]", i, j), acc[i][j], i * 4 + j);
            end
            start = tbl[k].start;
        end
        start = 1'b0;

        // Wrap boundary: 4 * 15 * 15 = 900, and 900 mod 512 = 388
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                load(1'b0, r, c, 15);
                load(1'b1, r, c, 15);
            end
        run_mult(1'b0, lat, fo);
        chk("wrap latency", lat, 12);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("wrap out_c[%0d][%0d]", i, j), acc[i][j], 388);

        // A load held during a multiply lands on the first IDLE cycle after DONE,
        // together with a start in that same cycle.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = 2'd0;
        ld_col   = 2'd0;
        ld_data  = 4'd7;
        cyc   = 1;
        early = 1'b0;
        while (!done && cyc < 50) begin
            if (ld_ready) early = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("held done cycle", cyc, 12);
        chk("held ready while busy", early, 0);
        chk("held ready at done", ld_ready, 0);
        @(negedge clk);
        chk("held ready first idle", ld_ready, 1);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        ld_valid = 1'b0;
        lat = 1;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("load+start latency", lat, 12);
        // Row 0: 7*15 + 3*225 = 780, and 780 mod 512 = 268. Other rows are unchanged at 388.
        chk("load+start out_c[0][0]", acc[0][0], 268);
        chk("load+start out_c[0][3]", acc[0][3], 268);
        chk("load+start out_c[1][1]", acc[1][1], 388);

        // Reset in the middle of FEED
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);           // C1
        start = 1'b0;
        repeat (4) @(negedge clk); // C5, FEED t=3
        chk("midrst busy before", busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst busy", busy, 0);
        chk("midrst arr_clr", arr_clr, 1);
        chk("midrst ld_ready", ld_ready, 1);
        chk("midrst done", done, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst idle arr_clr", arr_clr, 0);
        run_mult(1'b0, lat, fo);
        chk("post-rst latency", lat, 12);
        chk("post-rst feeds zero", fo, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("post-rst out_c[%0d][%0d]", i, j), acc[i][j], 0);

`ifdef SCHED_CHAIN_EN
        // Chained accumulation: I*I, then I*I again onto the previous results
        for (int i = 0; i < 4; i++) begin
            load(1'b0, i, i, 1);
            load(1'b1, i, i, 1);
        end
        run_mult(1'b0, lat, fo);
        chk("chain0 latency", lat, 12);
        run_mult(1'b1, lat, fo);
        chk("chain1 latency", lat, 11);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("chain out_c[%0d][%0d]", i, j), acc[i][j], (i == j) ? 2 : 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
